// File: rtl/seg_msg_pkg_341452019534398035.sv
// Shared types, glyph encoding and the default message ROM for the 7-segment message player.
package seg_msg_pkg_341452019534398035;

    typedef enum logic [1:0] {IDLE, SHOW, GAP, END_HOLD} state_t;

    typedef enum logic [4:0] {
        G_BLANK, G_0, G_1, G_2, G_3, G_H, G_E, G_L, G_O, G_R, G_P, G_G, G_DASH
    } glyph_t;

    localparam int ROM_MSGS  = 4;
    localparam int ROM_LEN   = 8;
    localparam int ROM_IDX_W = $clog2(ROM_LEN);

    // Segment patterns are {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph_to_seg(input glyph_t g);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (g)
            G_0:     seg = 7'b0111111;
            G_1:     seg = 7'b0000110;
            G_2:     seg = 7'b1011011;
            G_3:     seg = 7'b1001111;
            G_H:     seg = 7'b1110100;
            G_E:     seg = 7'b1111001;
            G_L:     seg = 7'b0111000;
            G_O:     seg = 7'b0111111;
            G_R:     seg = 7'b1010000;
            G_P:     seg = 7'b1110011;
            G_G:     seg = 7'b1111101;
            G_DASH:  seg = 7'b1000000;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    function automatic glyph_t msg_glyph(input int m, input int i);
        glyph_t row [ROM_LEN];
        logic [ROM_IDX_W-1:0] ii;
        row = '{default: G_BLANK};
        ii  = i[ROM_IDX_W-1:0];
        case (m)
            0:       row = '{G_H, G_E, G_L, G_L, G_O, G_BLANK, G_BLANK, G_BLANK};
            1:       row = '{G_R, G_P, G_O, G_G, G_BLANK, G_BLANK, G_BLANK, G_BLANK};
            2:       row = '{G_0, G_1, G_2, G_3, G_BLANK, G_BLANK, G_BLANK, G_BLANK};
            3:       row = '{G_DASH, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK};
            default: row = '{default: G_BLANK};
        endcase
        return (i >= 0 && i < ROM_LEN) ? row[ii] : G_BLANK;
    endfunction

    // Unknown message slots play as a single blank character
    function automatic int msg_len(input int m);
        int len;
        case (m)
            0:       len = 5;
            1:       len = 4;
            2:       len = 4;
            3:       len = 1;
            default: len = 1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/seg_msg_player_341452019534398035_tick.sv
// Free-running prescaler with clamped tap select; emits a one-cycle tick on each rising tap edge.
module seg_tick_gen_341452019534398035 #(
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DIV_W)-1:0] rate,
    output logic                     tick,
    output logic                     blink_phase
);

    localparam int RATE_W = $clog2(DIV_W);

    logic [DIV_W-1:0]  div_cnt;
    logic              tap_q;
    logic [RATE_W-1:0] tap_sel;

    assign tap_sel     = (int'(rate) >= DIV_W) ? RATE_W'(DIV_W - 1) : rate;
    assign tick        = div_cnt[tap_sel] & ~tap_q;
    assign blink_phase = div_cnt[DIV_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tap_q   <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tap_q   <= div_cnt[tap_sel];
        end
    end

endmodule

// File: rtl/seg_msg_player_341452019534398035.sv
// Message player top: advance control, character FSM, ROM lookup and registered segment outputs.
module seg_msg_player_341452019534398035
    import seg_msg_pkg_341452019534398035::*;
#(
    parameter int DIV_W   = 16,
    parameter int N_MSG   = 4,
    parameter int MSG_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(DIV_W)-1:0]   rate,
    input  logic [$clog2(N_MSG)-1:0]   msg_sel,
    input  logic                       run,
    input  logic                       step,
    input  logic                       blank_en,
    input  logic                       blink_en,
    output logic [6:0]                 segments,
    output logic                       decimal,
    output logic [$clog2(MSG_LEN)-1:0] char_idx
);

    localparam int IDX_W = $clog2(MSG_LEN);

    logic             tick;
    logic             blink_phase;
    logic             step_q;
    logic             adv;
    logic             msg_change;
    logic             is_last;
    logic [$clog2(N_MSG)-1:0] msg_q;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hold_q, hold_d;
    int               cur_len;
    logic [6:0]       glyph_seg;

    seg_tick_gen_341452019534398035 #(.DIV_W(DIV_W)) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .rate        (rate),
        .tick        (tick),
        .blink_phase (blink_phase)
    );

    assign adv        = run ? tick : (step & ~step_q);
    assign msg_change = (msg_sel != msg_q);
    assign char_idx   = idx_q;

    always_comb begin
        cur_len   = msg_len(int'(msg_q));
        if (cur_len > MSG_LEN) cur_len = MSG_LEN;
        is_last   = (int'(idx_q) == cur_len - 1);
        glyph_seg = glyph_to_seg(msg_glyph(int'(msg_q), int'(idx_q)));
    end

    // A message change restarts from the first character and swallows any coincident advance
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (msg_change) begin
            state_d = SHOW;
            idx_d   = '0;
            hold_d  = 1'b0;
        end else if (adv) begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                end
                SHOW: begin
                    if (is_last) begin
                        state_d = END_HOLD;
                        hold_d  = 1'b0;
                    end else if (blank_en) begin
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                GAP: begin
                    state_d = SHOW;
                    idx_d   = idx_q + IDX_W'(1);
                end
                END_HOLD: begin
                    if (hold_q) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        hold_d  = 1'b0;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs follow the FSM by one clock; blink gates segments only, never decimal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q    <= '0;
            step_q   <= 1'b0;
            segments <= 7'b0000000;
            decimal  <= 1'b0;
        end else begin
            msg_q    <= msg_sel;
            step_q   <= step;
            segments <= ((state_q == SHOW) && !(blink_en && blink_phase)) ? glyph_seg : 7'b0000000;
            decimal  <= (state_q == SHOW) && is_last;
        end
    end

endmodule

// File: doc/seg_msg_player_341452019534398035.md
# seg_msg_player_341452019534398035

Parametrised 7-segment message player: the successor to the fixed single-message HELLO display. It plays one of N_MSG stored glyph strings, one character per tick, from a programmable power-of-two prescaler. It supports auto-run, manual single-step, inter-character blanking, blink and end-of-message marking. It sits between the dip-switch inputs and the segment/decimal outputs of the user module.

## Interface
- DIV_W, 16: prescaler counter width; tick tap range 0..DIV_W-1
- N_MSG, 4: number of stored messages
- MSG_LEN, 8: maximum characters per message
- clk  in  1  system clock (io_in[0])
- rst_n  in  1  reset, asynchronous, active-low
- rate  in  $clog2(DIV_W)  prescaler tap select; values ≥ DIV_W clamp to DIV_W-1
- msg_sel  in  $clog2(N_MSG)  message select
- run  in  1  1 = auto-advance on tick; 0 = manual step
- step  in  1  manual advance; already synchronous to clk; rising edge counts
- blank_en  in  1  insert one blank tick between characters
- blink_en  in  1  blank segments while div_cnt[DIV_W-1]=1
- segments  out  7  registered glyph, bit order {g,f,e,d,c,b,a}
- decimal  out  1  registered; 1 while last character of message is shown
- char_idx  out  $clog2(MSG_LEN)  current character index

## Operation
- Prescaler: free-running div_cnt (DIV_W bits, wraps). tap_q registers div_cnt[rate]. tick = div_cnt[rate] & ~tap_q, a 1-cycle pulse every 2^(rate+1) clocks.
- Advance event adv = run ? tick : (step & ~step_q).
- msg_q registers msg_sel. A change (msg_sel ≠ msg_q) forces idx=0 and state SHOW on that edge. This takes priority over adv, which is consumed.
- FSM states:
  - IDLE: blank output. adv → SHOW, idx=0.
  - SHOW: output glyph(msg_q, idx). On adv:
    - idx < len-1: GAP if blank_en, else stay in SHOW with idx+1.
    - idx = len-1: END_HOLD, hold_cnt=0.
  - GAP: blank output. adv → SHOW, idx+1.
  - END_HOLD: blank output. On adv, hold_cnt+1; at the second adv → SHOW, idx=0 (wrap).
- run=0 with no step edge: state and idx freeze; display holds.
- Per-message length len(m) comes from the package and is always within 1..MSG_LEN. len=1 is legal: SHOW → END_HOLD → SHOW, same glyph.
- decimal = (state==SHOW) & (idx==len-1). decimal is not affected by blink.
- segments = glyph when state==SHOW and not (blink_en & div_cnt[DIV_W-1]); otherwise 7'b0000000.

## Timing
- Reset values: div_cnt=0, tap_q=0, step_q=0, msg_q=0, state=IDLE, idx=0, hold_cnt=0, segments=0, decimal=0, char_idx=0.
- The reset assertion clears all state immediately, including mid-message. After release the block restarts from IDLE.
- State and idx update on the edge where adv=1. segments and decimal update one clock later (1-cycle output latency). char_idx is the state register itself (0 latency).
- Changing rate mid-run may add or drop at most one tick. There is no other side effect.
- step held high produces exactly one advance.
- With run=1, step is ignored.

## Structure
- Package seg_msg_pkg_341452019534398035 contains:
  - state enum {IDLE, SHOW, GAP, END_HOLD}
  - 5-bit glyph codes and function glyph_to_seg
  - message ROM (N_MSG×MSG_LEN codes)
  - length table
- Default ROM:
  - msg 0 = HELLO (len 5)
  - msg 1 = RPOG (len 4)
  - msg 2 = 0123 (len 4)
  - msg 3 = "-" (len 1)
- Glyph values:
  - H=1110100
  - E=1111001
  - L=0111000
  - O=0111111
  - R=1010000
  - P=1110011
  - G=1111101
  - -=1000000
- Sub-module seg_tick_gen_341452019534398035: prescaler, tap clamp, tap_q and tick. Everything else (FSM, ROM lookup, output registers) lives in the top.

## Test plan
- Reset, run=1, rate=0, msg_sel=0, blank_en=0 → tick every 2 clocks. segments sequence: 0, 1110100, 1111001, 0111000, 0111000, 0111111 (decimal=1), 0, 0, then 1110100 again.
- msg_sel 0→1 while showing E → next edge idx=0. One clock later segments=1010000. Sequence continues 1110011, 0111111, 1111101.
- run=0, three single-cycle step pulses plus one 10-cycle step pulse on msg 0 from IDLE → H, E, L, L. The long pulse advances once only, and the display freezes between pulses.
- blank_en=1, msg 1 → R, 0, P, 0, O, 0, G (decimal=1), 0, 0, R. Each entry lasts one tick.
- blink_en=1, DIV_W=4, rate=0, showing a glyph → segments alternate 8 clocks glyph / 8 clocks blank. decimal stays steady.
- rst_n pulsed low asynchronously mid-message (between clock edges) → outputs 0 immediately. After release: IDLE, then H on the first tick. msg 3 with len=1 → "-" (decimal=1), 0, 0, "-".
